// File: rtl/led_pkg.sv
// Shared types and constants for the LED rate controller: blink-rate table,
// threshold width and the press-classifier state encoding.
package led_pkg;

  localparam int CNT_W = 27;

  // Terminal counts for each blink-rate mode; each entry halves the period.
  localparam logic [CNT_W-1:0] RATE_TABLE [0:7] = '{
    27'd50_000_000, 27'd25_000_000, 27'd12_500_000, 27'd6_250_000,
    27'd3_125_000,  27'd1_562_500,  27'd781_250,    27'd390_625
  };

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESSED   = 2'd1,
    LONG_HELD = 2'd2
  } state_t;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus counter debounce for an active-low button,
// producing registered single-cycle press and release strobes.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  output logic press_ev,
  output logic release_ev
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_r;
  logic          sync2_r;
  logic          level_r;
  logic          level_d_r;
  logic [DW-1:0] cnt_r;

  // Synchronize, debounce and edge-detect; level_r is the accepted btn_n level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_r    <= 1'b1;
      sync2_r    <= 1'b1;
      level_r    <= 1'b1;
      level_d_r  <= 1'b1;
      cnt_r      <= {DW{1'b0}};
      press_ev   <= 1'b0;
      release_ev <= 1'b0;
    end else begin
      sync1_r    <= btn_n;
      sync2_r    <= sync1_r;
      level_d_r  <= level_r;
      press_ev   <= level_d_r & ~level_r;
      release_ev <= ~level_d_r & level_r;
      if (sync2_r == level_r) begin
        cnt_r <= {DW{1'b0}};
      end else if (cnt_r == DEB_LAST) begin
        level_r <= sync2_r;
        cnt_r   <= {DW{1'b0}};
      end else begin
        cnt_r <= cnt_r + DW'(1);
      end
    end
  end

endmodule

// File: rtl/led_rate_ctrl.sv
// Button-driven blink-rate controller: short press steps the rate mode,
// long press toggles blinking; emits a one-cycle update strobe to the blinker.
module led_rate_ctrl
  import led_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int LONG_CYCLES     = 50_000_000,
  parameter int NUM_MODES       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_n,
  output logic [CNT_W-1:0] threshold,
  output logic             blink_en,
  output logic [2:0]       mode,
  output logic             rate_upd
);

  localparam int HW = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [2:0]    MODE_LAST = 3'(NUM_MODES - 1);

  logic          press_s;
  logic          release_s;
  state_t        state_r;
  state_t        state_s;
  logic [HW-1:0] hold_r;
  logic [HW-1:0] hold_s;
  logic          short_s;
  logic          long_s;
  logic [2:0]    mode_next_s;

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk        (clk),
    .reset      (reset),
    .btn_n      (btn_n),
    .press_ev   (press_s),
    .release_ev (release_s)
  );

  // Classifier state and hold counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      hold_r  <= {HW{1'b0}};
    end else begin
      state_r <= state_s;
      hold_r  <= hold_s;
    end
  end

  // Next state; the long threshold wins over a simultaneous release.
  always_comb begin
    state_s = state_r;
    hold_s  = hold_r;
    short_s = 1'b0;
    long_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (press_s) begin
          state_s = PRESSED;
          hold_s  = {HW{1'b0}};
        end else begin
          state_s = IDLE;
        end
      end
      PRESSED: begin
        if (hold_r == HOLD_LAST) begin
          state_s = LONG_HELD;
          long_s  = 1'b1;
        end else if (release_s) begin
          state_s = IDLE;
          short_s = 1'b1;
        end else begin
          hold_s = hold_r + HW'(1);
        end
      end
      LONG_HELD: begin
        if (release_s) begin
          state_s = IDLE;
        end else begin
          state_s = LONG_HELD;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Mode successor with wrap.
  always_comb begin
    mode_next_s = 3'd0;
    if (mode == MODE_LAST) begin
      mode_next_s = 3'd0;
    end else begin
      mode_next_s = mode + 3'd1;
    end
  end

  // Registered outputs; threshold is staged even while blinking is off.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode      <= 3'd0;
      threshold <= RATE_TABLE[0];
      blink_en  <= 1'b1;
      rate_upd  <= 1'b0;
    end else begin
      rate_upd <= short_s | long_s;
      if (short_s) begin
        mode      <= mode_next_s;
        threshold <= RATE_TABLE[mode_next_s];
      end
      if (long_s) begin
        blink_en <= ~blink_en;
      end
    end
  end

endmodule

// File: doc/led_rate_ctrl.md
Name: led_rate_ctrl

Overview:
- Upstream control stage for the LED blinker. Debounces one raw push-button and classifies each press as short or long.
- Short press: step to the next blink rate. Long press: toggle blinking on/off.
- Drives the blinker's terminal-count threshold, an enable, and a one-cycle update strobe. The blinker reloads its count on that strobe.

Parameters:
- DEBOUNCE_CYCLES, 1_000_000: consecutive stable synchronized cycles required to accept a button level change (20 ms at 50 MHz).
- LONG_CYCLES, 50_000_000: debounced-held cycles that make a press long (1 s at 50 MHz).
- NUM_MODES, 4: number of blink-rate modes, range 2..8.
- CNT_W, 27: width of the threshold output; matches the blinker counter.

Ports:
- clk  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-high reset.
- btn_n  in  1  raw push-button, active-low, asynchronous to clk.
- threshold  out  CNT_W  blinker terminal count for the current mode.
- blink_en  out  1  1 = blinker runs; 0 = blinker holds the LED off.
- mode  out  3  current mode index, 0..NUM_MODES-1.
- rate_upd  out  1  one-cycle pulse when threshold or blink_en changes.

Behaviour:
- Reset values (asynchronous on reset high): mode=0, threshold=RATE_TABLE[0]=50_000_000, blink_en=1, rate_upd=0. Internally: synchronizer flops=1 (released), debounced level=released, counters=0, FSM=IDLE.
- Synchronizer: two flops on btn_n. No other logic may see the raw btn_n.
- Debounce:
  - The stable counter counts while the synchronized level differs from the debounced level. It clears on any cycle where they match.
  - When the count reaches DEBOUNCE_CYCLES-1 with the difference still present, the debounced level flips on the next edge and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES is never accepted.
- Press/release events:
  - Single-cycle internal strobes from the edges of the debounced level.
  - Latency from a btn_n change to its event: 2 sync cycles + DEBOUNCE_CYCLES + 1.
- FSM:
  - IDLE: on press event, clear hold counter and go to PRESSED.
  - PRESSED: hold counter increments each cycle.
    - Release event before the count reaches LONG_CYCLES-1 → short press, back to IDLE.
    - Count reaches LONG_CYCLES-1 → long press, go to LONG_HELD.
  - LONG_HELD: wait. On release event go to IDLE with no further action.
  - Unused encodings return to IDLE.
- Short press:
  - mode <= mode+1, wrapping from NUM_MODES-1 to 0.
  - threshold <= RATE_TABLE[new mode].
  - rate_upd=1 for exactly one cycle, aligned with the new values.
  - blink_en is unchanged.
- Long press:
  - blink_en <= ~blink_en and rate_upd=1 for one cycle, both issued on the transition into LONG_HELD, not on release.
  - The release that follows changes nothing.
- All outputs are registered. Each output changes on the clock edge after its event is detected.
- The hold counter saturates. It does not advance in LONG_HELD, so holding the button indefinitely produces exactly one toggle.
- No counter wraps: the debounce counter is ceil(log2(DEBOUNCE_CYCLES)) bits, the hold counter ceil(log2(LONG_CYCLES)) bits, and compares use ==.
- Reset mid-press forces the reset values. If the button is still held when reset drops, the press is re-detected after the full debounce time, exactly like a fresh press.
- A press during blink_en=0 still steps the mode. The new threshold is staged for when blinking resumes.

Decomposition:
- Package led_pkg holds:
  - CNT_W.
  - RATE_TABLE[0..7] = 50_000_000, 25_000_000, 12_500_000, 6_250_000, 3_125_000, 1_562_500, 781_250, 390_625.
  - State typedef {IDLE, PRESSED, LONG_HELD}.
- One sub-module, btn_debounce (synchronizer + debounce + press/release strobes), parameterised by DEBOUNCE_CYCLES.
- The FSM, mode register and table lookup stay in led_rate_ctrl.

Test Plan (DEBOUNCE_CYCLES=4, LONG_CYCLES=20, NUM_MODES=4):
- Reset then idle 50 cycles → threshold=50_000_000, mode=0, blink_en=1, rate_upd never high.
- btn_n low 10 cycles then high → exactly one rate_upd; mode=1 and threshold=25_000_000 from that cycle on; blink_en=1.
- Four short presses → mode sequence 1,2,3,0; threshold back to 50_000_000 after the fourth.
- btn_n low 40 cycles → one rate_upd and blink_en=0 about 27 cycles after the falling edge; no event on release; mode unchanged. Repeat → blink_en=1.
- btn_n pulses low for 1, 2, 3 cycles separated by 1-cycle highs → no event, outputs unchanged.
- Assert reset for 2 cycles at hold count 10 with btn_n still low → reset values. After release of reset, the press is re-detected after 4+2+1 cycles. Releasing btn_n before it is held another 20 cycles yields a short press with mode=1.
